// File: rtl/conv_pkg.sv
// conv_pkg -- shared constants and FSM encoding for the convolution row scheduler.
//
// Contents:
//   ROW_W, N_ROWS, OUT_W, FL_W : default geometry (row word width, rows per frame,
//                                result width, 3x3x8-bit filter width)
//   state_t                    : scheduler FSM states
//   next_bank()                : modulo-3 increment shared by the bank pointer and
//                                the row-phase counter
package conv_pkg;

  localparam int ROW_W  = 800;
  localparam int N_ROWS = 30;
  localparam int OUT_W  = 1568;
  localparam int FL_W   = 72;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    WRITE,
    RUN,
    HOLD,
    DONE
  } state_t;

  // Three line buffers are used round-robin, so every rotating index wraps at 3.
  function automatic logic [1:0] next_bank(input logic [1:0] b);
    return (b == 2'd2) ? 2'd0 : b + 2'd1;
  endfunction

endpackage

// File: rtl/conv_row_sched_wdog.sv
// conv_row_sched_wdog -- RUN-state watchdog for conv_row_sched.
//
// Counts cycles spent waiting in RUN for a convolution result. The count is
// cleared on every entry into RUN and held while outside it.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   running  in   scheduler is in RUN this cycle
//   entering in   scheduler enters RUN at the next edge
//   expired  out  this is the TMO-th consecutive RUN cycle
module conv_row_sched_wdog #(
  parameter int TMO = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic running,
  input  logic entering,
  output logic expired
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (entering) begin
      count_reg <= '0;
    end else if (running) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // The first RUN cycle sees count 0, so the TMO-th one sees TMO-1.
  assign expired = running && (count_reg == CW'(TMO - 1));

endmodule

// File: rtl/conv_row_sched.sv
// conv_row_sched -- line-buffer scheduler for a 3x3 convolution over an image.
//
// Primes three line buffers with rows 0..2, then for each output row waits for
// a convolution result, hands it to the consumer with a valid/ready handshake,
// and reloads the buffer that held the oldest row with the next image row.
//
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   start                      one-cycle frame start (honoured only in IDLE)
//   fl_in  [72]                3x3 filter, captured on an accepted start
//   mem_rd_en, mem_rd_addr[5]  row memory read request / row index
//   mem_rd_data [ROW_W]        row data, valid the cycle after mem_rd_en
//   ram1, ram2, ram3 [ROW_W]   registered row words for line buffers 0/1/2
//   wr_en [3]                  one-hot line-buffer write strobe
//   FL [72]                    filter, stable for the frame
//   conv_valid, conv_out       result from the convolution datapath
//   res_valid, res_ready,
//   res_data                   result handshake to the consumer
//   res_row [5], row_phase [2] output-row index and buffer holding its top row
//   busy, done                 frame in progress / one-cycle end-of-frame pulse
//   err                        (only with CONV_ROW_SCHED_TIMEOUT_EN) sticky RUN timeout
//
// Build option: define CONV_ROW_SCHED_TIMEOUT_EN to add the RUN watchdog and
// the err output; without it RUN waits indefinitely for conv_valid.
module conv_row_sched #(
  parameter int ROW_W  = conv_pkg::ROW_W,
  parameter int N_ROWS = conv_pkg::N_ROWS,
  parameter int OUT_W  = conv_pkg::OUT_W,
  parameter int TMO    = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [conv_pkg::FL_W-1:0] fl_in,
  output logic                     mem_rd_en,
  output logic [4:0]               mem_rd_addr,
  input  logic [ROW_W-1:0]         mem_rd_data,
  output logic [ROW_W-1:0]         ram1,
  output logic [ROW_W-1:0]         ram2,
  output logic [ROW_W-1:0]         ram3,
  output logic [2:0]               wr_en,
  output logic [conv_pkg::FL_W-1:0] FL,
  input  logic                     conv_valid,
  input  logic [OUT_W-1:0]         conv_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [OUT_W-1:0]         res_data,
  output logic [4:0]               res_row,
  output logic [1:0]               row_phase,
  output logic                     busy,
  output logic                     done
`ifdef CONV_ROW_SCHED_TIMEOUT_EN
  ,output logic                    err
`endif
);

  import conv_pkg::*;

  state_t     state_reg;
  state_t     state_next;
  logic [4:0] fetch_idx_reg;  // image row fetched by the current/next load
  logic [1:0] bank_reg;       // line buffer the next load writes
  logic       last_row;

  assign last_row    = (res_row == 5'(N_ROWS - 3));
  assign mem_rd_addr = fetch_idx_reg;

`ifdef CONV_ROW_SCHED_TIMEOUT_EN
  logic expired;
  logic run_entry;

  assign run_entry = (state_next == RUN) && (state_reg != RUN);

  conv_row_sched_wdog #(
    .TMO(TMO)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .running  (state_reg == RUN),
    .entering (run_entry),
    .expired  (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      err <= 1'b0;
    end else if (expired && state_next == IDLE) begin
      err <= 1'b1;
    end
  end
`endif

  // State register plus the datapath registers that only change on specific
  // state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      fetch_idx_reg <= '0;
      bank_reg      <= '0;
      ram1          <= '0;
      ram2          <= '0;
      ram3          <= '0;
      FL            <= '0;
      res_data      <= '0;
      res_row       <= '0;
      row_phase     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            FL            <= fl_in;
            fetch_idx_reg <= '0;
            bank_reg      <= '0;
            res_row       <= '0;
            row_phase     <= '0;
          end
        end
        CAPT: begin
          case (bank_reg)
            2'd0:    ram1 <= mem_rd_data;
            2'd1:    ram2 <= mem_rd_data;
            default: ram3 <= mem_rd_data;
          endcase
        end
        WRITE: begin
          bank_reg      <= next_bank(bank_reg);
          fetch_idx_reg <= fetch_idx_reg + 5'd1;
        end
        RUN: begin
          if (conv_valid) begin
            res_data <= conv_out;
          end
        end
        HOLD: begin
          // Row counters advance only on acceptance so res_row/row_phase stay
          // stable for the whole handshake; the last row's values are kept.
          if (res_ready && !last_row) begin
            res_row   <= res_row + 5'd1;
            row_phase <= next_bank(row_phase);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_rd_en  = 1'b0;
    wr_en      = 3'b000;
    res_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        mem_rd_en  = 1'b1;
        state_next = CAPT;
      end
      CAPT: begin
        state_next = WRITE;
      end
      WRITE: begin
        wr_en = 3'b001 << bank_reg;
        // Rows 0 and 1 continue priming; every later load returns to RUN.
        state_next = (fetch_idx_reg < 5'd2) ? FETCH : RUN;
      end
      RUN: begin
        // A result arriving in the final watchdog cycle still wins.
        if (conv_valid) begin
          state_next = HOLD;
        end
`ifdef CONV_ROW_SCHED_TIMEOUT_EN
        else if (expired) begin
          state_next = IDLE;
        end
`endif
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = last_row ? DONE : FETCH;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_row_sched.sv
// tb_conv_row_sched -- directed, table-driven bench for conv_row_sched.
// Row memory returns {100{row[7:0]}} one cycle after a read request and all-ones
// otherwise; the convolution datapath is driven by hand with a per-row pattern.
// With CONV_ROW_SCHED_TIMEOUT_EN defined the DUT is built with TMO=16 and the
// timeout sequence is added.
module tb_conv_row_sched;

  localparam int ROW_W  = 800;
  localparam int N_ROWS = 30;
  localparam int OUT_W  = 1568;
  localparam int FL_W   = 72;
  localparam int N_OUT  = N_ROWS - 2;
`ifdef CONV_ROW_SCHED_TIMEOUT_EN
  localparam int TMO_P  = 16;
`else
  localparam int TMO_P  = 4096;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [FL_W-1:0]  fl_in;
  logic             mem_rd_en;
  logic [4:0]       mem_rd_addr;
  logic [ROW_W-1:0] mem_rd_data;
  logic [ROW_W-1:0] ram1, ram2, ram3;
  logic [2:0]       wr_en;
  logic [FL_W-1:0]  FL;
  logic             conv_valid;
  logic [OUT_W-1:0] conv_out;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;
  logic [4:0]       res_row;
  logic [1:0]       row_phase;
  logic             busy;
  logic             done;
`ifdef CONV_ROW_SCHED_TIMEOUT_EN
  logic             err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_row_sched #(
    .ROW_W (ROW_W),
    .N_ROWS(N_ROWS),
    .OUT_W (OUT_W),
    .TMO   (TMO_P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fl_in      (fl_in),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .ram1       (ram1),
    .ram2       (ram2),
    .ram3       (ram3),
    .wr_en      (wr_en),
    .FL         (FL),
    .conv_valid (conv_valid),
    .conv_out   (conv_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_row    (res_row),
    .row_phase  (row_phase),
    .busy       (busy),
    .done       (done)
`ifdef CONV_ROW_SCHED_TIMEOUT_EN
    ,.err       (err)
`endif
  );

  function automatic logic [ROW_W-1:0] row_word(input logic [4:0] r);
    logic [7:0] b;
    b = {3'b000, r};
    return {100{b}};
  endfunction

  function automatic logic [OUT_W-1:0] res_word(input int i);
    logic [31:0] v;
    v = 32'hC0DE_0000 + 32'(i);
    return {49{v}};
  endfunction

  // Row memory: data is only meaningful the cycle after a request.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= row_word(mem_rd_addr);
    else           mem_rd_data <= '1;
  end

  function automatic logic [ROW_W-1:0] ram_of(input int sel);
    case (sel)
      1:       return ram1;
      2:       return ram2;
      default: return ram3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got[63:0]=%0h want[63:0]=%0h t=%0t", name, act[63:0], exp[63:0], $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Priming table: one record per cycle after the accepted start.
  typedef struct {
    logic       rd_en;
    logic [4:0] addr;
    logic [2:0] wr;
    int         ram_sel;  // 0: no line-buffer write expected
    logic [4:0] row;
  } prime_vec_t;

  prime_vec_t pv [10];

  // Starts a frame from IDLE and walks the 10 priming cycles; ends in RUN.
  task automatic prime(input logic [FL_W-1:0] f, input bit valid_in_write);
    start = 1'b1;
    fl_in = f;
    step();
    start = 1'b0;
    fl_in = '0;
    for (int k = 0; k < 10; k++) begin
      chk("prime_rd_en", 64'(mem_rd_en), 64'(pv[k].rd_en));
      if (pv[k].rd_en) chk("prime_rd_addr", 64'(mem_rd_addr), 64'(pv[k].addr));
      chk("prime_wr_en", 64'(wr_en), 64'(pv[k].wr));
      chk("prime_busy", 64'(busy), 64'd1);
      if (pv[k].ram_sel != 0)
        chk_w("prime_ram", OUT_W'(ram_of(pv[k].ram_sel)), OUT_W'(row_word(pv[k].row)));
      if (k == 9) chk("prime_run_no_valid", 64'(res_valid), 64'd0);
      conv_valid = valid_in_write && (k == 8);
      conv_out   = conv_valid ? res_word(99) : '0;
      if (k < 9) step();
    end
    chk_w("prime_fl", OUT_W'(FL), OUT_W'(f));
    $display("frame primed fl=%0h", f);
  endtask

  // Serves every output row; optional 5-cycle stall on one row and optional
  // reset during the WRITE of a given image row.
  task automatic serve(input int stall_row, input int abort_load);
    for (int i = 0; i < N_OUT; i++) begin
      chk("run_rd_en", 64'(mem_rd_en), 64'd0);
      chk("run_res_valid", 64'(res_valid), 64'd0);
      conv_valid = 1'b1;
      conv_out   = res_word(i);
      step();
      conv_valid = 1'b0;
      conv_out   = '0;
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_res_row", 64'(res_row), 64'(i));
      chk("hold_row_phase", 64'(row_phase), 64'(i % 3));
      chk_w("hold_res_data", res_data, res_word(i));
      if (i == stall_row) begin
        res_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          chk("stall_res_valid", 64'(res_valid), 64'd1);
          chk("stall_res_row", 64'(res_row), 64'(i));
          chk_w("stall_res_data", res_data, res_word(i));
          chk("stall_rd_en", 64'(mem_rd_en), 64'd0);
          chk("stall_wr_en", 64'(wr_en), 64'd0);
        end
        res_ready = 1'b1;
      end
      $display("result row=%0d phase=%0d accepted", i, row_phase);
      step();
      if (i == N_OUT - 1) begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        start = 1'b1;  // same cycle as done: must be ignored
        step();
        start = 1'b0;
        chk("after_done", 64'(done), 64'd0);
        chk("after_done_busy", 64'(busy), 64'd0);
        step();
        chk("start_in_done_ignored", 64'(busy), 64'd0);
      end else begin
        chk("load_rd_en", 64'(mem_rd_en), 64'd1);
        chk("load_rd_addr", 64'(mem_rd_addr), 64'(i + 3));
        step();
        chk("capt_wr_en", 64'(wr_en), 64'd0);
        step();
        chk("load_wr_en", 64'(wr_en), 64'(3'b001 << (i % 3)));
        chk_w("load_ram", OUT_W'(ram_of(i % 3 + 1)), OUT_W'(row_word(5'(i + 3))));
        if (i + 3 == abort_load) begin
          rst = 1'b1;
          #1;
          chk("rst_wr_en", 64'(wr_en), 64'd0);
          chk("rst_busy", 64'(busy), 64'd0);
          chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
          chk("rst_res_valid", 64'(res_valid), 64'd0);
          chk("rst_done", 64'(done), 64'd0);
          chk("rst_res_row", 64'(res_row), 64'd0);
          chk("rst_row_phase", 64'(row_phase), 64'd0);
          chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
          chk_w("rst_ram1", OUT_W'(ram1), '0);
          chk_w("rst_ram2", OUT_W'(ram2), '0);
          chk_w("rst_ram3", OUT_W'(ram3), '0);
          chk_w("rst_fl", OUT_W'(FL), '0);
          chk_w("rst_res_data", res_data, '0);
          step();
          chk("rst_next_busy", 64'(busy), 64'd0);
          rst = 1'b0;
          step();
          $display("frame aborted by reset at load of row %0d", i + 3);
          return;
        end
        step();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    pv[0] = '{1'b1, 5'd0, 3'b000, 0, 5'd0};
    pv[1] = '{1'b0, 5'd0, 3'b000, 0, 5'd0};
    pv[2] = '{1'b0, 5'd0, 3'b001, 1, 5'd0};
    pv[3] = '{1'b1, 5'd1, 3'b000, 0, 5'd0};
    pv[4] = '{1'b0, 5'd0, 3'b000, 0, 5'd0};
    pv[5] = '{1'b0, 5'd0, 3'b010, 2, 5'd1};
    pv[6] = '{1'b1, 5'd2, 3'b000, 0, 5'd0};
    pv[7] = '{1'b0, 5'd0, 3'b000, 0, 5'd0};
    pv[8] = '{1'b0, 5'd0, 3'b100, 3, 5'd2};
    pv[9] = '{1'b0, 5'd0, 3'b000, 0, 5'd0};

    rst        = 1'b0;
    start      = 1'b0;
    fl_in      = '0;
    conv_valid = 1'b0;
    conv_out   = '0;
    res_ready  = 1'b1;
    #1 rst = 1'b1;
    step();
    step();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_wr_en", 64'(wr_en), 64'd0);
    chk("reset_rd_en", 64'(mem_rd_en), 64'd0);
    chk("reset_res_valid", 64'(res_valid), 64'd0);
    chk_w("reset_fl", OUT_W'(FL), '0);
    rst = 1'b0;
    step();

    // Frame 1: prime, full rotation with a ready consumer, FL retained.
    prime(72'hA1_B2_C3_D4_E5_F6_07_18_29, 1'b0);
    serve(-1, -1);
    chk_w("fl_retained", OUT_W'(FL), OUT_W'(72'hA1_B2_C3_D4_E5_F6_07_18_29));

    // Frame 2: conv_valid during WRITE and start in RUN are ignored; stall row 4.
    prime(72'h11_22_33_44_55_66_77_88_99, 1'b1);
    conv_valid = 1'b0;
    step();
    chk("ign_valid_res_valid", 64'(res_valid), 64'd0);
    chk("ign_valid_busy", 64'(busy), 64'd1);
    start = 1'b1;
    fl_in = 72'hFF_EE_DD_CC_BB_AA_99_88_77;
    step();
    start = 1'b0;
    fl_in = '0;
    chk("ign_start_rd_en", 64'(mem_rd_en), 64'd0);
    chk("ign_start_res_valid", 64'(res_valid), 64'd0);
    chk("ign_start_busy", 64'(busy), 64'd1);
    chk_w("ign_start_fl", OUT_W'(FL), OUT_W'(72'h11_22_33_44_55_66_77_88_99));
    serve(4, -1);

    // Frame 3: reset during the WRITE of row 10, then a clean restart.
    prime(72'h0F_0E_0D_0C_0B_0A_09_08_07, 1'b0);
    serve(-1, 10);
    prime(72'h5A_5A_5A_5A_5A_5A_5A_5A_5A, 1'b0);
    serve(-1, -1);

`ifdef CONV_ROW_SCHED_TIMEOUT_EN
    // Timeout: no result ever arrives; 16 RUN cycles force IDLE with err set.
    prime(72'h12_34_56_78_9A_BC_DE_F0_01, 1'b0);
    for (int c = 1; c < 16; c++) step();
    chk("tmo_busy_before", 64'(busy), 64'd1);
    chk("tmo_err_before", 64'(err), 64'd0);
    step();
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_err", 64'(err), 64'd1);
    step();
    chk("tmo_err_sticky", 64'(err), 64'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("tmo_err_cleared", 64'(err), 64'd0);
    $display("timeout sequence complete");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
